// File: rtl/sm_ram_arbiter.sv
// ============================================================================
//  Module      : sm_ram_arbiter
//  Description : Serialises CPU and user-port accesses onto the shared
//                single-port data RAM. Optional macro SM_RAM_ARB_STARVE_EN
//                adds a user-port anti-starvation wait counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_ram_arbiter #(
    parameter int RAM_AW   = 6,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    input  logic              usr_req,
    input  logic              usr_we,
    input  logic [31:0]       usr_addr,
    input  logic [31:0]       usr_wdata,
    output logic              usr_ack,
    output logic [31:0]       usr_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic c_OWN_CPU = 1'b0;
    localparam logic c_OWN_USR = 1'b1;

    state_t      r_state;
    logic        r_owner;
    logic        r_we;
    logic [31:0] r_cpuRdata;
    logic [31:0] r_usrRdata;
    logic        w_usrWins;

`ifdef SM_RAM_ARB_STARVE_EN
    localparam logic [4:0] c_MAX_WAIT = 5'(MAX_WAIT);

    logic [3:0] r_wait;

    // The user port is "waiting" whenever it requests and is not being served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= 4'd0;
        end else if (usr_ack) begin
            r_wait <= 4'd0;
        end else if (usr_req && !(r_state != IDLE && r_owner == c_OWN_USR)
                     && r_wait != 4'hF) begin
            r_wait <= r_wait + 4'd1;
        end
    end

    assign w_usrWins = usr_req & (~cpu_req | ({1'b0, r_wait} >= c_MAX_WAIT));
`else
    assign w_usrWins = usr_req & ~cpu_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner    <= c_OWN_CPU;
            r_we       <= 1'b0;
            r_cpuRdata <= 32'd0;
            r_usrRdata <= 32'd0;
            cpu_ack    <= 1'b0;
            usr_ack    <= 1'b0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= 32'd0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req || usr_req) begin
                        r_owner   <= w_usrWins;
                        r_we      <= w_usrWins ? usr_we : cpu_we;
                        ram_we    <= w_usrWins ? usr_we : cpu_we;
                        ram_addr  <= w_usrWins ? usr_addr[RAM_AW+1:2]
                                               : cpu_addr[RAM_AW+1:2];
                        ram_wdata <= w_usrWins ? usr_wdata : cpu_wdata;
                        busy      <= 1'b1;
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_we  <= 1'b0;
                    cpu_ack <= (r_owner == c_OWN_CPU);
                    usr_ack <= (r_owner == c_OWN_USR);
                    r_state <= DONE;
                end
                DONE: begin
                    cpu_ack <= 1'b0;
                    usr_ack <= 1'b0;
                    busy    <= 1'b0;
                    if (!r_we) begin
                        if (r_owner == c_OWN_CPU) begin
                            r_cpuRdata <= ram_rdata;
                        end else begin
                            r_usrRdata <= ram_rdata;
                        end
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM data only arrives in DONE, so the ack cycle forwards it directly;
    // the holding register keeps it stable until that port's next read.
    assign cpu_rdata = (cpu_ack && !r_we) ? ram_rdata : r_cpuRdata;
    assign usr_rdata = (usr_ack && !r_we) ? ram_rdata : r_usrRdata;

    logic w_unused;
    assign w_unused = &{1'b0, cpu_addr[1:0], cpu_addr[31:RAM_AW+2],
                        usr_addr[1:0], usr_addr[31:RAM_AW+2], (MAX_WAIT != 0)};

endmodule

`default_nettype wire

// File: tb/tb_sm_ram_arbiter.sv
// ============================================================================
//  Module      : tb_sm_ram_arbiter
//  Description : Scoreboard bench for sm_ram_arbiter with a behavioural RAM
//                reference model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm_ram_arbiter;

    localparam int RAM_AW   = 6;
    localparam int MAX_WAIT = 8;
    localparam int DEPTH    = 1 << RAM_AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]       cpu_addr = 32'd0, cpu_wdata = 32'd0;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;
    logic              usr_req = 1'b0, usr_we = 1'b0;
    logic [31:0]       usr_addr = 32'd0, usr_wdata = 32'd0;
    logic              usr_ack;
    logic [31:0]       usr_rdata;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'd0;
    logic              busy;

    sm_ram_arbiter #(.RAM_AW(RAM_AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
        .usr_ack(usr_ack), .usr_rdata(usr_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM seen by the arbiter
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct { bit isCpu; bit isRead; logic [31:0] data; } resp_t;
    typedef struct { bit we; logic [5:0] idx; logic [31:0] data; } acc_t;

    resp_t       respQ[$];
    acc_t        accQ[$];
    logic [31:0] refMem [DEPTH];
    int          tests = 0;
    int          fails = 0;
    bit          monOn = 1'b1;
    bit          prevBusy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: each access hits word (addr/4) mod DEPTH, in service order.
    function automatic void modelAccess(input bit isCpu, input bit we,
                                        input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] word = addr >> 2;
        int idx = int'(word % 32'(DEPTH));
        accQ.push_back('{we, 6'(idx), data});
        if (we) begin
            refMem[idx] = data;
            respQ.push_back('{isCpu, 1'b0, 32'h0});
        end else begin
            respQ.push_back('{isCpu, 1'b1, refMem[idx]});
        end
    endfunction

    // Monitor: RAM strobes and acks are matched against the expectation queues.
    always @(negedge clk) begin
        resp_t r;
        acc_t  a;
        if (rst_n && monOn) begin
            if (busy && !prevBusy) begin
                if (accQ.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_access: got addr %h, expected none", ram_addr);
                end else begin
                    a = accQ.pop_front();
                    check("ram_we", 32'(ram_we), 32'(a.we));
                    check("ram_addr", 32'(ram_addr), 32'(a.idx));
                    if (a.we) check("ram_wdata", ram_wdata, a.data);
                end
            end else begin
                check("ram_we_outside_access", 32'(ram_we), 32'd0);
            end
            check("ack_overlap", 32'(cpu_ack & usr_ack), 32'd0);
            if (cpu_ack || usr_ack) begin
                if (respQ.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_ack: got cpu_ack %b usr_ack %b, expected none",
                             cpu_ack, usr_ack);
                end else begin
                    r = respQ.pop_front();
                    check("ack_port", 32'(cpu_ack), 32'(r.isCpu));
                    if (r.isRead) check("rdata", r.isCpu ? cpu_rdata : usr_rdata, r.data);
                end
            end
        end
        prevBusy = rst_n ? busy : 1'b0;
    end

    task automatic issue(input bit cOn, input bit cWe, input logic [31:0] cAddr,
                         input logic [31:0] cData, input bit uOn, input bit uWe,
                         input logic [31:0] uAddr, input logic [31:0] uData, input bit chg);
        int n = 0;
        bit cDone = !cOn;
        bit uDone = !uOn;
        if (cOn) modelAccess(1'b1, cWe, cAddr, cData);
        if (uOn) modelAccess(1'b0, uWe, uAddr, uData);
        @(negedge clk);
        if (cOn) begin cpu_req = 1; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cData; end
        if (uOn) begin usr_req = 1; usr_we = uWe; usr_addr = uAddr; usr_wdata = uData; end
        while (!(cDone && uDone) && n < 20) begin
            @(negedge clk);
            n++;
            if (chg && n == 1) cpu_addr = cAddr + 32'd4;
            if (!cDone && cpu_ack) begin
                cDone = 1; cpu_req = 0;
                check("cpu_ack_latency", 32'(n), 32'd2);
            end
            if (!uDone && usr_ack) begin
                uDone = 1; usr_req = 0;
                check("usr_ack_latency", 32'(n), cOn ? 32'd5 : 32'd2);
            end
        end
        if (!(cDone && uDone)) begin
            check("ack_timeout", 32'({cDone, uDone}), 32'd3);
            cpu_req = 0; usr_req = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int n, cAcks, uAcks, uFirst;
        for (int i = 0; i < DEPTH; i++) begin mem[i] = 32'd0; refMem[i] = 32'd0; end

        repeat (3) @(negedge clk);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_usr_ack", 32'(usr_ack), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_usr_rdata", usr_rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(0, 0, 0, 0, 1, 1, 32'h4, 32'h00110011, 0);
        issue(0, 0, 0, 0, 1, 0, 32'h4, 32'h0, 0);
        check("usr_read_back", usr_rdata, 32'h00110011);
        issue(1, 0, 32'h8, 0, 1, 1, 32'hC, 32'h0C0C0C0C, 0);
        issue(1, 1, 32'h100, 32'hAAAA0000, 0, 0, 0, 0, 0);
        issue(1, 1, 32'h7, 32'hBBBB0001, 0, 0, 0, 0, 0);
        issue(1, 1, 32'h8, 32'hCAFE0002, 0, 0, 0, 0, 0);
        issue(1, 0, 32'h8, 0, 0, 0, 0, 0, 1);
        issue(0, 0, 0, 0, 1, 0, 32'h100, 0, 0);
        check("cpu_rdata_held", cpu_rdata, 32'hCAFE0002);

        // Reset during ACCESS of a write; written value matches the model either way
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'hC; cpu_wdata = refMem[3];
        accQ.push_back('{1'b1, 6'd3, refMem[3]});
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ram_we", 32'(ram_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cpu_ack", 32'(cpu_ack), 32'd0);
        check("abort_usr_ack", 32'(usr_ack), 32'd0);
        cpu_req = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'd0);

        // Continuous CPU reads against a pending user read
        monOn = 0;
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8;
        usr_req = 1; usr_we = 0; usr_addr = 32'h10;
        cAcks = 0; uAcks = 0; uFirst = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (cpu_ack) cAcks++;
            if (usr_ack) begin
                uAcks++;
                if (uFirst < 0) begin
                    uFirst = i;
                    check("starve_usr_rdata", usr_rdata, refMem[4]);
                    usr_req = 0;
                end
            end
        end
`ifdef SM_RAM_ARB_STARVE_EN
        check("starve_bound", 32'(uFirst >= 1 && uFirst <= MAX_WAIT + 6), 32'd1);
`else
        check("starve_usr_acks", 32'(uAcks), 32'd0);
        check("starve_cpu_acks", 32'(cAcks), 32'd33);
`endif
        n = 0;
        while (!cpu_ack && n < 10) begin @(negedge clk); n++; end
        check("starve_cpu_drop", 32'(cpu_ack), 32'd1);
        cpu_req = 0;
        if (usr_req) begin
            n = 0;
            while (!usr_ack && n < 10) begin @(negedge clk); n++; end
            check("released_usr_ack", 32'(usr_ack), 32'd1);
            check("released_usr_rdata", usr_rdata, refMem[4]);
            usr_req = 0;
        end
        repeat (3) @(negedge clk);
        monOn = 1;

        for (int i = 0; i < 40; i++) begin
            int mode = int'($urandom_range(0, 2));
            issue(mode != 1, 1'($urandom), $urandom, $urandom,
                  mode != 0, 1'($urandom), $urandom, $urandom, 0);
        end

        repeat (4) @(negedge clk);
        check("resp_queue_drained", 32'(respQ.size()), 32'd0);
        check("acc_queue_drained", 32'(accQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sm_ram_arbiter.md
Name: sm_ram_arbiter

Overview:
Two-port arbiter sharing the single-port data RAM inside sm_matrix between the CPU data bus and the user/debug port (userAddr/userWe/userWData/userRData on sm_top). Each requester holds a request until it receives a one-cycle ack. The arbiter serialises the accesses, drives the RAM and returns read data. It sits between sm_cpu/sm_top user pins and sm_ram and replaces the current direct user-port mux.

Parameters:
RAM_AW, 6, RAM word-address width (depth = 2**RAM_AW words)
MAX_WAIT, 8, user-port starvation limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock (cpuClk domain)
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  CPU write enable (1 = write, 0 = read)
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  32  CPU read data, valid when cpu_ack = 1
usr_req, usr_we, usr_addr, usr_wdata  in  1/1/32/32  user port, same semantics as CPU
usr_ack  out  1  one-cycle completion pulse to user port
usr_rdata  out  32  user read data, valid when usr_ack = 1
ram_addr  out  RAM_AW  RAM word address
ram_we  out  1  RAM write strobe
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, synchronous, valid the cycle after ram_addr is presented
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: FSM = IDLE; cpu_ack = usr_ack = 0; ram_we = 0; ram_addr = 0; ram_wdata = 0; cpu_rdata = usr_rdata = 0; busy = 0; owner register = CPU; wait counter = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: sample the requests.
  - If any request is high, latch the winner's we, addr and wdata, set owner, and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration (base): fixed priority, CPU over user. If both requests are high in the same cycle, the CPU wins.
- ACCESS (1 cycle):
  - ram_addr = latched addr[RAM_AW+1:2]; addr[1:0] and bits above RAM_AW+1 are ignored, so addresses wrap modulo depth.
  - ram_we = latched we; ram_wdata = latched wdata.
  - Go to DONE.
- DONE (1 cycle):
  - ram_we = 0; assert the owner's ack.
  - On a read, the owner's rdata = ram_rdata, registered and held until that port's next read completes.
  - On a write, rdata is unchanged.
  - Go to IDLE.
- Latency: request sampled in IDLE at cycle N -> RAM strobe at N+1 -> ack at N+2. Back-to-back throughput is one access per 3 cycles.
- Handshake: a requester must keep req, we, addr and wdata stable until ack. Changes after the request is latched are ignored. Req still high in the cycle after ack counts as a new request.
- The non-owner's ack is never asserted. cpu_ack and usr_ack are never high together.
- Reset mid-operation: return to IDLE immediately. ram_we and both acks drop asynchronously. An in-flight write may or may not reach the RAM; no ack is issued for it.
- ram_we is high only in ACCESS and only for writes.

Optional Feature:
SM_RAM_ARB_STARVE_EN
- Enabled:
  - A saturating 4-bit wait counter increments each cycle usr_req is high while the user port is not the owner.
  - It clears when usr_ack is asserted.
  - In IDLE, if both requests are high and wait >= MAX_WAIT, the user port wins.
- Disabled: counter is absent, and arbitration is pure CPU priority; a continuously requesting CPU can starve the user port indefinitely.

Test Plan:
- Reset, then user write to addr 0x4 with wdata 0x00110011 -> ram_we pulses once with ram_addr = 1 at cycle +1; usr_ack at cycle +2. A subsequent user read of 0x4 returns usr_rdata = 0x00110011 with usr_ack.
- CPU and user both request in the same cycle (CPU read of 0x8, user write of 0xC) -> cpu_ack at +2, usr_ack at +5, and the acks never overlap.
- CPU write to 0x100 with RAM_AW = 6 -> ram_addr = 0 (wrap); CPU write to 0x7 -> ram_addr = 1 (byte bits ignored).
- Assert rst_n low during ACCESS of a write -> ram_we, busy and both acks are 0 immediately; after release, FSM is in IDLE and no ack is issued for the aborted write.
- CPU holds req continuously while the user requests. With SM_RAM_ARB_STARVE_EN and MAX_WAIT = 8, usr_ack occurs within 8 + 3 cycles. Without the macro, no usr_ack occurs over 100 cycles.
- Change cpu_addr from 0x8 to 0xC while in ACCESS -> the RAM still sees word 2 and cpu_rdata returns the word-2 contents.
